ram_master: RTL
===============

Name: ram_master

Overview:
- Initiator-side access engine for the single-port synchronous RAM.
- Accepts single or burst read/write requests from the CPU datapath over valid/ready handshakes.
- Sequences the RAM's we/re/addr/data_in pins and accounts for the RAM's one-cycle registered read latency.
- Ignores RAM data_out except in the one cycle where it is guaranteed valid; data_out is high-Z after any cycle without re.

Parameters:
WIDTH, 8, data word width; matches RAM WIDTH
DEPTH, 256, RAM word count; AW = $clog2(DEPTH)
LEN_W, 4, burst length field width; burst beats = req_len+1 (1..2^LEN_W)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  AW  start word address
req_len  in  LEN_W  beats minus one
wr_valid  in  1  write data beat valid
wr_data  in  WIDTH  write data beat
wr_ready  out  1  write beat accepted when valid&ready
rd_valid  out  1  read data beat valid
rd_data  out  WIDTH  read data beat
rd_last  out  1  final beat of read burst, qualified by rd_valid
rd_ready  in  1  consumer accepts read beat
busy  out  1  high in any state except IDLE
ram_we  out  1  to RAM we
ram_re  out  1  to RAM re
ram_addr  out  AW  to RAM addr
ram_wdata  out  WIDTH  to RAM data_in
ram_rdata  in  WIDTH  from RAM data_out

Behaviour:
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP.
- Reset (async, immediate): state=IDLE; addr, beat counter, rd_data = 0; rd_valid=0, rd_last=0, busy=0; ram_we=ram_re=0, ram_addr=0, ram_wdata=0.
- Reset mid-burst aborts with no further RAM write or read. RAM contents already written stay. No partial response.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr/req_len/req_write and clear the beat counter.
  - Go to WRITE if req_write, else RD_ISSUE.
- Other states: req_ready=0; req_valid is ignored and not queued.
- WRITE:
  - wr_ready=1.
  - ram_we = wr_valid (combinational); ram_addr=addr; ram_wdata=wr_data.
  - On handshake: addr++ and count++. If the beat was number req_len, go to IDLE.
  - wr_valid low: no RAM access, stay.
  - Throughput one beat/cycle.
- RD_ISSUE: ram_re=1, ram_addr=addr for exactly one cycle -> RD_WAIT.
- RD_WAIT:
  - ram_re=0; ram_rdata is valid this cycle.
  - Register it into rd_data at cycle end.
  - Set rd_valid=1, and rd_last=1 if count==req_len.
  - Go to RD_RESP.
- RD_RESP:
  - rd_valid, rd_data, rd_last are held stable until rd_ready.
  - On handshake: rd_valid=0. If last, go to IDLE. Otherwise addr++, count++, go to RD_ISSUE.
- Read latency: request handshake in cycle T gives rd_valid in cycle T+3. Minimum 3 cycles per read beat.
- ram_rdata is sampled only in RD_WAIT, so high-Z or stale values never reach rd_data.
- ram_we and ram_re are never high together; both are 0 in IDLE.
- wr_ready=0 outside WRITE; rd_valid=0 outside RD_RESP.
- Address wrap: addr increments modulo DEPTH (DEPTH-1 -> 0).
- Counter: LEN_W bits. A max-length burst of 2^LEN_W beats completes correctly.
- Back-to-back: IDLE is always visited between requests, so there is at least one idle cycle between bursts.

Test Plan:
- Single write addr 0x10 data 0xA5, then single read 0x10 -> one ram_we pulse at 0x10; rd_valid exactly 3 cycles after read handshake; rd_data=0xA5; rd_last=1.
- Write burst addr 0xFE, len 3, data 11,22,33,44 -> RAM writes at FE,FF,00,01. Read burst back -> 11,22,33,44 in order, rd_last only on 44.
- Read burst len 2 with rd_ready low 5 cycles per beat -> rd_data/rd_last stable while waiting; no extra ram_re pulses; 3 beats total.
- Write burst len 1 with wr_valid gap of 3 cycles -> ram_we only on valid cycles; addresses consecutive; busy held throughout.
- rst asserted mid-cycle during beat 2 of 4-beat write -> all outputs zero immediately; IDLE; later read shows only beats 0-1 written.
- req_valid held during active burst -> req_ready=0; request accepted only in the cycle after the burst returns to IDLE.

Source files
------------

// File: rtl/ram_master.sv
// Initiator-side access engine for a single-port synchronous RAM with one-cycle read latency.
// Turns single/burst read and write requests into RAM we/re/addr/data sequences.
module ram_master #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LEN_W = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  // write data channel
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  // read response channel
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  input  logic             rd_ready,
  output logic             busy,
  // RAM pins
  output logic             ram_we,
  output logic             ram_re,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdWait,
    StRdResp
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [AW-1:0]    r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_rd_last;
  logic [AW-1:0]    w_addr_inc;
  logic             w_cnt_last;

  // Explicit wrap keeps modulo-DEPTH behaviour for non-power-of-two depths.
  assign w_addr_inc = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
  assign w_cnt_last = (r_cnt == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (r_state)
      StIdle: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_d = req_write ? StWrite : StRdIssue;
        end
      end
      StWrite: begin
        wr_ready  = 1'b1;
        ram_we    = wr_valid;
        ram_addr  = r_addr;
        ram_wdata = wr_data;
        if (wr_valid && w_cnt_last) begin
          w_state_d = StIdle;
        end
      end
      StRdIssue: begin
        ram_re    = 1'b1;
        ram_addr  = r_addr;
        w_state_d = StRdWait;
      end
      StRdWait: begin
        w_state_d = StRdResp;
      end
      StRdResp: begin
        if (rd_ready) begin
          w_state_d = r_rd_last ? StIdle : StRdIssue;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_addr <= req_addr;
            r_len  <= req_len;
            r_cnt  <= '0;
          end
        end
        StWrite: begin
          if (wr_valid) begin
            r_addr <= w_addr_inc;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        StRdWait: begin
          // Only cycle where ram_rdata is guaranteed driven by the RAM.
          r_rd_data  <= ram_rdata;
          r_rd_valid <= 1'b1;
          r_rd_last  <= w_cnt_last;
        end
        StRdResp: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (!r_rd_last) begin
              r_addr <= w_addr_inc;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_last  = r_rd_last;

endmodule
